reorder_rd_ctrl: RTL
====================

# reorder_rd_ctrl

Read-side controller for the double-buffered reorder FIFO. It drains a completed bank of the two-port RAM in ascending address order and presents the entries as a valid/ready stream. It then hands the bank back to the write side. The block sits between the RAM's read port and the downstream consumer, and absorbs the RAM's one-cycle read latency and downstream backpressure without losing data or stalling throughput.

## Interface
- `DW`, 18, data width; matches the RAM word.
- `AW`, 7, RAM address width. MSB selects the bank; bank depth is `NENT = 2**(AW-1)`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `bank_rdy` input 2: one-cycle pulse per bank; writer has filled bank b.
- `bank_free` output 2: one-cycle pulse; bank b fully drained and returned to the writer.
- `rd_addr` output AW: RAM read address, combinational from internal state.
- `rd_data` input DW: RAM read data, valid one cycle after `rd_addr` is presented.
- `out_valid` output 1: output entry valid.
- `out_ready` input 1: consumer accepts; a transfer happens when `out_valid & out_ready`.
- `out_data` output DW: entry data.
- `out_last` output 1: final entry (index `NENT-1`) of the current bank.
- `err` output 1: sticky protocol-error flag (see Configuration).

## Operation
- State: `pending[1:0]`, current bank `cur`, read index `idx` (AW-1 bits), in-flight flag `infl`, 2-entry output buffer, FSM state.
- `pending[b]` is set at the edge following a `bank_rdy[b]` pulse. It is cleared at the edge on which `bank_free[b]` pulses.
- FSM states:
  - IDLE: if `pending[cur]`, issue the read of `{cur, 0}` and go to DRAIN. Otherwise stay.
  - DRAIN: issue reads while `idx < NENT` and credit is available. After the read of `NENT-1` is issued, go to FLUSH.
  - FLUSH: wait until the entry tagged last is accepted on the output. On that edge pulse `bank_free[cur]`, toggle `cur`, clear `idx`, and go to IDLE.
- Issue rule: a read issues in a cycle when `(buffer_count + infl) < 2`, or when a downstream transfer occurs that same cycle. `rd_addr = {cur, idx}`; `idx` increments on each issue.
- Data returning from the RAM is written into the buffer the cycle after issue. The last entry carries `out_last=1`.
- Order: bank 0 drains first after reset, and banks then alternate strictly. A pending non-current bank waits.
- `bank_rdy` for a bank that is already pending or being drained is a protocol violation. It is ignored: the pending state is unchanged.
- `bank_rdy` arriving on the same edge as `bank_free` for that bank re-arms it: the set wins.
- `out_data` and `out_last` hold stable while `out_valid & ~out_ready`.

## Timing
- Reset values: `out_valid=0`, `out_last=0`, `out_data=0`, `bank_free=0`, `err=0`, `rd_addr=0`. FSM is IDLE, `cur=0`, `pending=0`, buffer empty.
- Reset mid-drain discards in-flight and buffered data and produces no `bank_free` pulse.
- Latency: `bank_rdy` in cycle T gives the first read issue in T+1, data captured at the end of T+2, and `out_valid=1` in T+3.
- Throughput: one entry per clock while `out_ready` is held high. There is a two-cycle bubble between banks: the FLUSH→IDLE→DRAIN turnaround.
- `bank_free` is asserted in the cycle after the last transfer and lasts exactly one cycle.

## Configuration
- `REORDER_RD_ERR_EN` defined: `err` is set on any protocol violation and stays set until `rst`. Violations are:
  - `bank_rdy[b]` while `pending[b]` is set;
  - `bank_rdy` with both bits set in the same cycle while both banks are pending.
- `REORDER_RD_ERR_EN` undefined: `err` is tied to 0 and the detection logic is absent. Violations are still ignored.

## Structure
- Shared package `reorder_pkg`:
  - FSM state enum `rd_state_t` (IDLE, DRAIN, FLUSH);
  - `NBANK = 2`;
  - helper function for bank depth from AW.
- Sub-module `rd_skid2`: 2-entry synchronous FIFO of `{last, data}`, with push, pop, count and head outputs. Parameter is DW.

## Test plan
- Reset, then `bank_rdy=2'b01`, `out_ready=1`, NENT=64: expect 64 transfers in consecutive cycles, first `out_valid` 3 cycles after the pulse, `out_data` equal to RAM addresses 0..63, `out_last` only on the 64th, and `bank_free=2'b01` one cycle later.
- Both banks ready back-to-back, `out_ready=1`: bank 0 drains fully, then bank 1 (addresses 64..127) after exactly a 2-cycle gap; `bank_free` pulses 01, then 10.
- Random `out_ready` at 30% duty: no dropped or duplicated entries, `out_data` stable while stalled, buffer never exceeds 2.
- `bank_rdy[0]` re-pulsed during the drain of bank 0: the second pulse is ignored, only one drain occurs, and `err=1` with the macro defined (0 without).
- Assert `rst` mid-drain at entry 20: outputs return to reset values next cycle, no `bank_free`. A fresh `bank_rdy[0]` then drains from address 0.

Source files
------------

// File: rtl/reorder_pkg.sv
// Shared definitions for the reorder FIFO read-side controller.
//   rd_state_t : read FSM state encoding (IDLE, DRAIN, FLUSH)
//   NBANK      : number of RAM banks (double buffered)
//   bank_depth : entries per bank for a given RAM address width
package reorder_pkg;

    localparam int NBANK = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } rd_state_t;

    // The address MSB selects the bank, so each bank holds 2**(aw-1) words.
    function automatic int bank_depth(input int aw);
        return 1 << (aw - 1);
    endfunction

endpackage

// File: rtl/reorder_rd_ctrl_if.sv
// Downstream valid/ready stream carrying drained RAM entries.
//   out_valid : entry valid (from producer)
//   out_ready : consumer accepts (from consumer)
//   out_data  : entry data
//   out_last  : final entry of the bank
// Handshake: a transfer happens on every rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_valid, out_data and
// out_last hold stable until that transfer; out_ready may toggle freely.
interface reorder_rd_ctrl_if #(parameter int DW = 18) ();

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/reorder_rd_ctrl_rd_skid2.sv
// rd_skid2: two-entry synchronous FIFO of {last, data} that absorbs the RAM
// read latency and downstream backpressure.
//   clk, rst             : clock, synchronous active-high reset
//   push, push_last/data : write an entry (never pushed while full)
//   pop                  : drop the head entry (never popped while empty)
//   count                : number of stored entries (0..2)
//   head_last/head_data  : oldest entry; all-zero storage after reset
module rd_skid2 #(
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          push_last,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic          head_last,
    output logic [DW-1:0] head_data
);

    logic [DW:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign {head_last, head_data} = mem[rd_ptr];

endmodule

// File: rtl/reorder_rd_ctrl.sv
// reorder_rd_ctrl: read-side controller of the double-buffered reorder FIFO.
// Drains a filled bank in ascending address order onto a valid/ready stream,
// then returns the bank to the writer with a one-cycle bank_free pulse.
// Banks are drained strictly alternately, bank 0 first after reset.
//   clk, rst   : clock, synchronous active-high reset
//   bank_rdy   : per-bank pulse, writer has filled the bank
//   bank_free  : per-bank pulse, bank drained and returned
//   rd_addr    : RAM read address {bank, index}, combinational
//   rd_data    : RAM read data, one cycle after rd_addr
//   dn         : downstream stream (reorder_rd_ctrl_if.master)
//   err        : sticky protocol-error flag
//   state      : current FSM state, for observation
// Build option: define REORDER_RD_ERR_EN to enable err; otherwise err is 0.
module reorder_rd_ctrl
    import reorder_pkg::*;
#(
    parameter int DW = 18,
    parameter int AW = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NBANK-1:0]       bank_rdy,
    output logic [NBANK-1:0]       bank_free,
    output logic [AW-1:0]          rd_addr,
    input  logic [DW-1:0]          rd_data,
    reorder_rd_ctrl_if.master      dn,
    output logic                   err,
    output rd_state_t              state
);

    localparam int NENT = bank_depth(AW);
    localparam int IW   = AW - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NENT - 1);

    rd_state_t        state_q;
    rd_state_t        state_d;
    logic [NBANK-1:0] pending;
    logic             cur;
    logic [IW-1:0]    idx;
    logic             infl;
    logic             infl_last;

    logic             issue;
    logic             free_set;
    logic             credit;
    logic             xfer;
    logic             last_xfer;
    logic [2:0]       occ;
    logic [NBANK-1:0] cur_mask;
    logic [NBANK-1:0] clr;
    logic [NBANK-1:0] set;

    logic [1:0]       buf_count;
    logic             buf_last;
    logic [DW-1:0]    buf_data;
    logic             valid;

    // Output buffer; RAM data lands here the cycle after its read issues.
    rd_skid2 #(.DW(DW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (infl),
        .push_last (infl_last),
        .push_data (rd_data),
        .pop       (xfer),
        .count     (buf_count),
        .head_last (buf_last),
        .head_data (buf_data)
    );

    assign valid        = (buf_count != 2'd0);
    assign dn.out_valid = valid;
    assign dn.out_data  = valid ? buf_data : '0;
    assign dn.out_last  = valid & buf_last;

    assign xfer      = valid & dn.out_ready;
    assign last_xfer = xfer & buf_last;

    // A slot is free if buffered plus in-flight entries leave room, or if an
    // entry leaves this cycle; this keeps one entry per clock under full flow.
    assign occ    = {1'b0, buf_count} + {2'b00, infl};
    assign credit = (occ < 3'd2) | xfer;

    assign rd_addr  = {cur, idx};
    assign cur_mask = cur ? 2'b10 : 2'b01;
    assign state    = state_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending[cur]) state_d = DRAIN;
            DRAIN:   if (credit && idx == LAST_IDX) state_d = FLUSH;
            FLUSH:   if (last_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        issue    = 1'b0;
        free_set = 1'b0;
        case (state_q)
            // The buffer is always empty in IDLE, so no credit check needed.
            IDLE:    issue    = pending[cur];
            DRAIN:   issue    = credit;
            FLUSH:   free_set = last_xfer;
            default: ;
        endcase
    end

    // A bank is cleared on the edge its free pulse is launched; a bank_rdy on
    // that same edge re-arms it. Otherwise bank_rdy on a pending bank is ignored.
    assign clr = free_set ? cur_mask : '0;
    assign set = bank_rdy & (~pending | clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            cur       <= 1'b0;
            idx       <= '0;
            infl      <= 1'b0;
            infl_last <= 1'b0;
            bank_free <= '0;
        end else begin
            pending   <= (pending & ~clr) | set;
            infl      <= issue;
            infl_last <= issue && (idx == LAST_IDX);
            bank_free <= clr;
            if (issue) begin
                idx <= idx + 1'b1;
            end
            if (free_set) begin
                cur <= ~cur;
                idx <= '0;
            end
        end
    end

`ifdef REORDER_RD_ERR_EN
    logic viol;

    assign viol = (|(bank_rdy & pending & ~clr)) | ((&bank_rdy) & (&pending));

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (viol) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
